// File: rtl/hop_word_sched.sv
// Hop word scheduler: issues one table word per hop interval to the scan-chain
// serializer using a start/done handshake, with a programmable hop-period timer.
//
// state      | meaning
// IDLE       | sequence stopped, waiting for run
// LOAD       | latch table[hop_idx] onto ser_data, pulse ser_start next cycle
// WAIT_DONE  | word in flight, waiting for ser_done
// WAIT_TICK  | word done, waiting for the hop-period tick
module hop_word_sched #(
    parameter int TX_BITS_WIDTH = 128,
    parameter int NHOPS         = 8,
    parameter int HOP_IDX_WIDTH = 3,
    parameter int PERIOD_WIDTH  = 32,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     tbl_wr_en,
    input  logic [HOP_IDX_WIDTH-1:0] tbl_wr_hop,
    input  logic [1:0]               tbl_wr_lane,
    input  logic [31:0]              tbl_wr_data,
    input  logic                     run,
    input  logic [HOP_IDX_WIDTH:0]   num_hops,
    input  logic [PERIOD_WIDTH-1:0]  hop_period,
    output logic                     ser_start,
    output logic [TX_BITS_WIDTH-1:0] ser_data,
    input  logic                     ser_done,
    output logic                     busy,
    output logic [HOP_IDX_WIDTH-1:0] cur_hop,
    output logic [CNT_WIDTH-1:0]     hop_count,
    output logic                     missed_hop
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LOAD      = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;
    localparam logic [1:0] S_WAIT_TICK = 2'd3;

    logic [1:0]               state;
    logic [1:0]               state_nxt;
    logic [TX_BITS_WIDTH-1:0] tbl [NHOPS];
    logic [HOP_IDX_WIDTH-1:0] hop_idx;
    logic [PERIOD_WIDTH-1:0]  timer;
    logic [PERIOD_WIDTH-1:0]  eff_period;
    logic [HOP_IDX_WIDTH:0]   eff_num;
    logic                     tick;
    logic                     tick_late;
    logic                     last_idx;

    assign eff_period = (hop_period < PERIOD_WIDTH'(2)) ? PERIOD_WIDTH'(2) : hop_period;
    assign eff_num    = (num_hops == '0) ? (HOP_IDX_WIDTH+1)'(1) :
                        (num_hops > (HOP_IDX_WIDTH+1)'(NHOPS)) ? (HOP_IDX_WIDTH+1)'(NHOPS) :
                        num_hops;
    // >= rather than == so a live period shrink below the current count still ticks
    assign tick       = (timer >= eff_period - PERIOD_WIDTH'(1));
    assign last_idx   = ({1'b0, hop_idx} >= eff_num - (HOP_IDX_WIDTH+1)'(1));
    assign busy       = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (run) state_nxt = S_LOAD;
            S_LOAD:      state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (ser_done) begin
                    if (!run)                    state_nxt = S_IDLE;
                    else if (tick_late || tick)  state_nxt = S_LOAD;
                    else                         state_nxt = S_WAIT_TICK;
                end
            end
            S_WAIT_TICK: begin
                if (!run)       state_nxt = S_IDLE;
                else if (tick)  state_nxt = S_LOAD;
            end
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Timer is cleared on entry to LOAD and counts through LOAD itself, so the
    // LOAD-to-LOAD spacing equals eff_period when the serializer is on time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            hop_idx    <= '0;
            timer      <= '0;
            tick_late  <= 1'b0;
            ser_start  <= 1'b0;
            ser_data   <= '0;
            cur_hop    <= '0;
            hop_count  <= '0;
            missed_hop <= 1'b0;
        end else begin
            state     <= state_nxt;
            ser_start <= 1'b0;
            if (state == S_IDLE || state_nxt == S_LOAD)
                timer <= '0;
            else if (!tick)
                timer <= timer + PERIOD_WIDTH'(1);

            case (state)
                S_IDLE: begin
                    if (run) begin
                        hop_idx    <= '0;
                        missed_hop <= 1'b0;
                    end
                end
                S_LOAD: begin
                    ser_data  <= tbl[hop_idx];
                    cur_hop   <= hop_idx;
                    ser_start <= 1'b1;
                    tick_late <= 1'b0;
                end
                S_WAIT_DONE: begin
                    if (ser_done) begin
                        hop_count <= hop_count + CNT_WIDTH'(1);
                        hop_idx   <= last_idx ? '0 : hop_idx + HOP_IDX_WIDTH'(1);
                        if (run && tick_late)
                            missed_hop <= 1'b1;
                    end else if (tick) begin
                        tick_late <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Non-blocking write gives read-before-write against a same-cycle LOAD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NHOPS; i++)
                tbl[i] <= '0;
        end else if (tbl_wr_en) begin
            tbl[tbl_wr_hop][{tbl_wr_lane, 5'd0} +: 32] <= tbl_wr_data;
        end
    end

endmodule
